// File: rtl/param_sequence_generator_if.sv
// param_sequence_generator_if: control inputs and valid/ready word stream of the sequence generator.
interface param_sequence_generator_if #(parameter int WIDTH = 8) ();
  logic             enable;
  logic [1:0]       mode;
  logic [WIDTH-1:0] step;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] hi;
  logic             load;
  logic [WIDTH-1:0] seed;
  logic [WIDTH-1:0] data;
  logic             valid;
  logic             ready;
  logic             wrap;
  modport master (
    input  enable, mode, step, lo, hi, load, seed, ready,
    output data, valid, wrap
  );
  modport slave (
    output enable, mode, step, lo, hi, load, seed, ready,
    input  data, valid, wrap
  );
endinterface

// File: rtl/param_sequence_generator.sv
// param_sequence_generator: up/down/LFSR/Gray word stream with bounds, seeding and a wrap flag.
module param_sequence_generator #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] TAPS        = 8'hB8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input logic clk,
  input logic rst,
  param_sequence_generator_if.master bus
);
  logic [WIDTH-1:0] state, origin, lo_e, hi_e, lfsr_s, nxt, ld_val, nxt_data, ld_data;
  logic [WIDTH:0]   sum, diff;
  logic             full, nwrap;
  always_comb begin
    full     = bus.lo > bus.hi;
    lo_e     = full ? '0 : bus.lo;
    hi_e     = full ? '1 : bus.hi;
    sum      = {1'b0, state} + {1'b0, bus.step};
    diff     = {1'b0, state} - {1'b0, bus.step};
    lfsr_s   = (state == '0) ? WIDTH'(1) : state;
    nxt      = state;
    nwrap    = 1'b0;
    if (bus.mode == 2'b10) begin
      nxt   = (lfsr_s >> 1) ^ (lfsr_s[0] ? TAPS : '0);
      nwrap = nxt == origin;
    end else if (bus.mode == 2'b01) begin
      nwrap = state <= lo_e || diff[WIDTH] || diff[WIDTH-1:0] < lo_e;
      nxt   = nwrap ? hi_e : diff[WIDTH-1:0];
    end else begin
      nwrap = state >= hi_e || sum > {1'b0, hi_e};
      nxt   = nwrap ? lo_e : sum[WIDTH-1:0];
    end
    ld_val   = (bus.mode == 2'b10 && bus.seed == '0) ? WIDTH'(1) : bus.seed;
    nxt_data = (bus.mode == 2'b11) ? nxt ^ (nxt >> 1) : nxt;
    ld_data  = (bus.mode == 2'b11) ? ld_val ^ (ld_val >> 1) : ld_val;
  end
  // load beats transfer beats enable; a held word only moves on transfer or load
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RESET_VALUE;
      origin    <= RESET_VALUE;
      bus.data  <= RESET_VALUE;
      bus.valid <= 1'b0;
      bus.wrap  <= 1'b0;
    end else if (bus.load) begin
      state     <= ld_val;
      origin    <= ld_val;
      bus.data  <= ld_data;
      bus.valid <= 1'b0;
      bus.wrap  <= 1'b0;
    end else if (bus.valid && bus.ready) begin
      state     <= nxt;
      bus.data  <= nxt_data;
      bus.wrap  <= nwrap;
      bus.valid <= bus.enable;
    end else if (bus.enable) begin
      bus.valid <= 1'b1;
    end
  end
endmodule
